// File: rtl/ram_dump_engine_if.sv
// Bundles the engine's synchronous RAM read port and its valid/ready byte stream.
interface ram_dump_engine_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic                  dump_last;

  modport master (
    output ram_rd_en, ram_rd_addr, dump_data, dump_valid, dump_last,
    input  ram_rd_data, dump_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, dump_data, dump_valid, dump_last,
    output ram_rd_data, dump_ready
  );
endinterface

// File: rtl/ram_dump_engine.sv
// Reads RAM[START_ADDR..END_ADDR] after a halt rising edge or start pulse and streams
// HEADER, each data byte, then an 8-bit wrap-around checksum on a valid/ready port.
module ram_dump_engine #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    START_ADDR = 0,
  parameter int                    END_ADDR   = 15,
  parameter logic [DATA_WIDTH-1:0] HEADER     = 'hA5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               halt,
  input  logic               start,
  output logic               busy,
  output logic               done,
  ram_dump_engine_if.master  bus
);

  typedef enum logic [2:0] {IDLE, HDR, RD, WT, TX, CK, DN} state_e;

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(END_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  halt_q;
  logic                  trigger;

  assign trigger = (halt & ~halt_q) | start;

  // NOTE: every output and next-state value gets a default before the case, so no
  // path through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    sum_d           = sum_q;
    data_d          = data_q;
    bus.ram_rd_en   = 1'b0;
    bus.ram_rd_addr = '0;
    bus.dump_valid  = 1'b0;
    bus.dump_data   = '0;
    bus.dump_last   = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = HDR;
          addr_d  = FIRST_ADDR;
          sum_d   = '0;
        end
      end
      HDR: begin
        busy           = 1'b1;
        bus.dump_valid = 1'b1;
        bus.dump_data  = HEADER;
        if (bus.dump_ready) state_d = RD;
      end
      RD: begin
        busy            = 1'b1;
        bus.ram_rd_en   = 1'b1;
        bus.ram_rd_addr = addr_q;
        state_d         = WT;
      end
      WT: begin
        busy    = 1'b1;
        data_d  = bus.ram_rd_data;
        sum_d   = sum_q + bus.ram_rd_data;
        state_d = TX;
      end
      TX: begin
        busy           = 1'b1;
        bus.dump_valid = 1'b1;
        bus.dump_data  = data_q;
        if (bus.dump_ready) begin
          // Equality against the last address, never a wrap test, so END_ADDR at the
          // top of the address space still terminates.
          if (addr_q == LAST_ADDR) begin
            state_d = CK;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = RD;
          end
        end
      end
      CK: begin
        busy           = 1'b1;
        bus.dump_valid = 1'b1;
        bus.dump_data  = sum_q;
        bus.dump_last  = 1'b1;
        if (bus.dump_ready) state_d = DN;
      end
      DN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values and the order of statements here does not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= FIRST_ADDR;
      sum_q   <= '0;
      data_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      halt_q  <= halt;
    end
  end

endmodule

// File: tb/tb_ram_dump_engine.sv
// Self-checking bench for ram_dump_engine: table-driven frames, multi-cycle corner
// sequences and randomized RAM/back-pressure checked against a frame-level model.
module tb_ram_dump_engine;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    bit         use_halt;
    int         ready_mode;
    logic [7:0] exp_sum;
    int         exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic halt_a, start_a, busy_a, done_a;
  logic halt_b, start_b, busy_b, done_b;
  logic ready;

  logic [7:0] ram_a [16];
  logic [7:0] ram_b [16];

  beat_t      q_a[$], q_b[$];
  logic [3:0] rd_q_a[$], rd_q_b[$];
  int         done_cnt_a, done_cnt_b;

  bit         stall_a;
  logic [7:0] hold_data_a;
  logic       hold_last_a;

  int checks = 0;
  int errors = 0;

  ram_dump_engine_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_a ();
  ram_dump_engine_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_b ();

  ram_dump_engine dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .halt    (halt_a),
    .start   (start_a),
    .busy    (busy_a),
    .done    (done_a),
    .bus     (bus_a.master)
  );

  ram_dump_engine #(.START_ADDR(3), .END_ADDR(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .halt    (halt_b),
    .start   (start_b),
    .busy    (busy_b),
    .done    (done_b),
    .bus     (bus_b.master)
  );

  always #5 clk = ~clk;

  assign bus_a.dump_ready = ready;
  assign bus_b.dump_ready = ready;

  // Synchronous-read RAM models, one cycle of latency.
  always @(posedge clk) if (bus_a.ram_rd_en) bus_a.ram_rd_data <= ram_a[bus_a.ram_rd_addr];
  always @(posedge clk) if (bus_b.ram_rd_en) bus_b.ram_rd_data <= ram_b[bus_b.ram_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Mid-cycle monitors: anything valid & ready here transfers on the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("stall valid held", bus_a.dump_valid, 1'b1);
        check("stall data held", bus_a.dump_data, hold_data_a);
        check("stall last held", bus_a.dump_last, hold_last_a);
      end
      if (bus_a.dump_valid && bus_a.dump_ready) q_a.push_back('{bus_a.dump_data, bus_a.dump_last});
      if (bus_a.ram_rd_en) rd_q_a.push_back(bus_a.ram_rd_addr);
      if (done_a) done_cnt_a++;
      stall_a     = bus_a.dump_valid & ~bus_a.dump_ready;
      hold_data_a = bus_a.dump_data;
      hold_last_a = bus_a.dump_last;
      if (bus_b.dump_valid && bus_b.dump_ready) q_b.push_back('{bus_b.dump_data, bus_b.dump_last});
      if (bus_b.ram_rd_en) rd_q_b.push_back(bus_b.ram_rd_addr);
      if (done_b) done_cnt_b++;
    end
  end

  task automatic clear_a();
    q_a.delete();
    rd_q_a.delete();
    done_cnt_a = 0;
  endtask

  task automatic drive_ready(input int mode, input int cyc);
    case (mode)
      0:       ready = 1'b1;
      1:       ready = cyc[0];
      default: ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Called one step after a rising edge with the trigger already applied (cycle 1).
  task automatic wait_done(input int mode, input int budget, output int cycles, output bit found);
    cycles = 1;
    found  = 1'b0;
    drive_ready(mode, cycles);
    while (!found && cycles < budget) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      cycles++;
      if (done_a) found = 1'b1;
      drive_ready(mode, cycles);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame model: header, the dumped window in address order, then the byte sum mod 256.
  task automatic check_frame_a(input string tag);
    beat_t exp[$];
    int    s = 0;
    exp.push_back('{8'hA5, 1'b0});
    for (int i = 0; i < 16; i++) begin
      exp.push_back('{ram_a[i], 1'b0});
      s += int'(ram_a[i]);
    end
    exp.push_back('{8'(s % 256), 1'b1});
    check({tag, " frame length"}, q_a.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_a.size(); i++)
      check($sformatf("%s beat %0d {data,last}", tag, i), q_a[i], exp[i]);
    check({tag, " read count"}, rd_q_a.size(), 16);
    for (int i = 0; i < 16 && i < rd_q_a.size(); i++)
      check($sformatf("%s read addr %0d", tag, i), rd_q_a[i], i);
    check({tag, " done pulses"}, done_cnt_a, 1);
    check({tag, " busy after done"}, busy_a, 1'b0);
  endtask

  initial begin
    vec_t vecs[5];
    int   cycles;
    bit   found;

    vecs[0] = '{8'h01, 8'h01, 1'b1, 0, 8'h88, 52};
    vecs[1] = '{8'hFF, 8'h00, 1'b0, 0, 8'hF0, 52};
    vecs[2] = '{8'h01, 8'h01, 1'b0, 1, 8'h88, 0};
    vecs[3] = '{8'h10, 8'h10, 1'b0, 0, 8'h80, 52};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 2, 8'h00, 0};

    reset_n = 1'b0;
    halt_a = 1'b0; start_a = 1'b0;
    halt_b = 1'b0; start_b = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ram_a[i] = 8'(i + 1);
      ram_b[i] = 8'($urandom);
    end
    ram_b[3] = 8'h7E;
    #2;
    check("reset dump_valid", bus_a.dump_valid, 1'b0);
    check("reset dump_last", bus_a.dump_last, 1'b0);
    check("reset dump_data", bus_a.dump_data, 8'h00);
    check("reset ram_rd_en", bus_a.ram_rd_en, 1'b0);
    check("reset busy", busy_a, 1'b0);
    check("reset done", done_a, 1'b0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    check("idle busy", busy_a, 1'b0);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) ram_a[i] = 8'(int'(vecs[v].base) + i * int'(vecs[v].step));
      halt_a = 1'b0;
      idle(2);
      clear_a();
      if (vecs[v].use_halt) halt_a = 1'b1;
      else start_a = 1'b1;
      wait_done(vecs[v].ready_mode, 400, cycles, found);
      check($sformatf("vec%0d done seen", v), found, 1'b1);
      if (vecs[v].exp_cycles != 0) check($sformatf("vec%0d latency", v), cycles, vecs[v].exp_cycles);
      idle(1);
      if (q_a.size() > 0) check($sformatf("vec%0d checksum", v), q_a[q_a.size()-1].data, vecs[v].exp_sum);
      check_frame_a($sformatf("vec%0d", v));
    end

    // Retriggers while busy are dropped; a later start in IDLE gives a second frame.
    for (int i = 0; i < 16; i++) ram_a[i] = 8'(i + 1);
    halt_a = 1'b0;
    ready  = 1'b1;
    idle(2);
    clear_a();
    halt_a = 1'b1;
    cycles = 1;
    found  = 1'b0;
    while (!found && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      start_a = (cycles == 10);
      if (cycles == 15) halt_a = 1'b0;
      if (cycles == 20) halt_a = 1'b1;
      if (done_a) found = 1'b1;
    end
    start_a = 1'b0;
    check("retrigger done seen", found, 1'b1);
    idle(60);
    check_frame_a("retrigger");
    clear_a();
    start_a = 1'b1;
    wait_done(0, 200, cycles, found);
    check("second frame done seen", found, 1'b1);
    idle(1);
    check_frame_a("second frame");

    // start and a halt edge in the same cycle give one frame.
    halt_a = 1'b0;
    idle(2);
    clear_a();
    halt_a  = 1'b1;
    start_a = 1'b1;
    wait_done(0, 200, cycles, found);
    check("same-cycle done seen", found, 1'b1);
    idle(60);
    check_frame_a("same-cycle");

    // Reset while the 5th data byte is presented; halt stays high and re-triggers.
    halt_a = 1'b0;
    idle(2);
    clear_a();
    halt_a = 1'b1;
    found  = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      #1;
      if (q_a.size() == 6 && bus_a.dump_valid) found = 1'b1;
    end
    check("reached 5th data byte", found, 1'b1);
    check("5th data byte value", bus_a.dump_data, 8'h05);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset dump_valid", bus_a.dump_valid, 1'b0);
    check("async reset busy", busy_a, 1'b0);
    check("async reset ram_rd_en", bus_a.ram_rd_en, 1'b0);
    idle(2);
    clear_a();
    reset_n = 1'b1;
    wait_done(0, 200, cycles, found);
    check("post-reset done seen", found, 1'b1);
    check("post-reset latency", cycles, 52);
    idle(1);
    check_frame_a("post-reset");

    // Single-address window on the second instance.
    q_b.delete();
    rd_q_b.delete();
    done_cnt_b = 0;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk);
      #1;
      if (done_b) found = 1'b1;
    end
    check("window done seen", found, 1'b1);
    idle(1);
    check("window length", q_b.size(), 3);
    if (q_b.size() == 3) begin
      check("window header", q_b[0], {8'hA5, 1'b0});
      check("window data", q_b[1], {8'h7E, 1'b0});
      check("window checksum", q_b[2], {8'h7E, 1'b1});
    end
    check("window read count", rd_q_b.size(), 1);
    foreach (rd_q_b[i]) check("window read addr", rd_q_b[i], 4'd3);
    check("window done pulses", done_cnt_b, 1);

    // Randomized RAM contents and back-pressure.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) ram_a[i] = 8'($urandom);
      idle(2);
      clear_a();
      start_a = 1'b1;
      wait_done(2, 400, cycles, found);
      check($sformatf("random%0d done seen", it), found, 1'b1);
      idle(1);
      check_frame_a($sformatf("random%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
